// File: rtl/fifo_read_drainer.sv
// fifo_read_drainer: read-side consumer for the team FIFO.
// Issues RREQ, captures RD one cycle after each accepted request into a
// 2-entry register buffer, and presents the words as a valid/ready stream.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   en              - allow new read requests
//   e               - FIFO empty flag
//   RREQ            - FIFO read request (combinational)
//   RD              - FIFO read data, valid the cycle after an RREQ cycle
//   out_valid/out_data/out_ready - output stream
//   words_read      - wrapping count of words popped from the FIFO
//   busy            - read in flight or buffer non-empty
module fifo_read_drainer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             e,
   output logic             RREQ,
   input  logic [WIDTH-1:0] RD,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] words_read,
   output logic             busy
);

   localparam int unsigned OCC_W = 2;
   localparam int unsigned PEND_W = 3;

   logic [OCC_W-1:0]  occ_q, occ_d;
   logic              inflight_q, inflight_d;
   logic              head_q, head_d;
   logic              tail_q, tail_d;
   logic [WIDTH-1:0]  mem_q [2];
   logic [WIDTH-1:0]  mem_d [2];
   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  out_data_q, out_data_d;
   logic [CNT_W-1:0]  words_read_q, words_read_d;
   logic              busy_q, busy_d;

   logic              pop_c;
   logic              rreq_c;
   logic [PEND_W-1:0] pending_c;

   // Request only if the word would still fit after this cycle's pop.
   // Never negative: pop implies occ >= 1.
   always_comb begin
      pop_c     = out_valid_q & out_ready;
      pending_c = PEND_W'(occ_q) + PEND_W'(inflight_q) - PEND_W'(pop_c);
      rreq_c    = !rst & en & !e & (pending_c < PEND_W'(2));
   end

   assign RREQ = rreq_c;

   // Buffer push/pop, counters and registered outputs.
   always_comb begin
      occ_d        = occ_q;
      inflight_d   = rreq_c;
      head_d       = head_q;
      tail_d       = tail_q;
      mem_d        = mem_q;
      words_read_d = words_read_q;

      // The word requested last cycle is on RD now.
      if (inflight_q) begin
         mem_d[tail_q] = RD;
         tail_d        = ~tail_q;
         words_read_d  = words_read_q + CNT_W'(1);
      end
      if (pop_c) begin
         head_d = ~head_q;
      end
      occ_d = occ_q + OCC_W'(inflight_q) - OCC_W'(pop_c);

      out_valid_d = (occ_d != '0);
      out_data_d  = mem_d[head_d];
      busy_d      = inflight_d | (occ_d != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q        <= '0;
         inflight_q   <= 1'b0;
         head_q       <= 1'b0;
         tail_q       <= 1'b0;
         mem_q[0]     <= '0;
         mem_q[1]     <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         words_read_q <= '0;
         busy_q       <= 1'b0;
      end else begin
         occ_q        <= occ_d;
         inflight_q   <= inflight_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         mem_q        <= mem_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         words_read_q <= words_read_d;
         busy_q       <= busy_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign words_read = words_read_q;
   assign busy       = busy_q;

endmodule

// File: doc/fifo_read_drainer.md
Name: fifo_read_drainer

Overview:
- Read-side consumer for the team's `fifo` block.
- Drives `RREQ`, captures `RD` one cycle after each accepted request, and presents the words as a valid/ready stream through a 2-entry output buffer.
- Throughput is one word per clock when downstream is always ready.
- Sits between the FIFO read port and any stream sink. Single clock domain; the FIFO's `clkr` is tied to this block's `clk`.

Parameters:
- WIDTH, 8, data width; must match FIFO `RD` width.
- CNT_W, 16, width of the words-read counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  when 0, no new RREQ is issued; in-flight and buffered words still complete.
- e  input  1  FIFO empty flag.
- RREQ  output  1  FIFO read request; combinational.
- RD  input  WIDTH  FIFO read data, valid the cycle after an RREQ cycle.
- out_valid  output  1  output word available.
- out_data  output  WIDTH  output word (buffer head).
- out_ready  input  1  sink accepts when out_valid and out_ready are both 1.
- words_read  output  CNT_W  count of words popped from the FIFO.
- busy  output  1  high if a read is in flight or the buffer is non-empty.

Behaviour:
- Reset:
  - Synchronous, active-high; takes priority over all other actions.
  - Clears: occ=0, inflight=0, out_valid=0, out_data=0, words_read=0, busy=0.
  - RREQ is 0 while rst=1.
  - Buffer contents are discarded. A word returned on RD in the cycle after reset deasserts is ignored, because inflight=0.
- State:
  - occ (0..2): buffered word count.
  - inflight (1 bit): RREQ was issued last cycle.
  - Head/tail pointers (1 bit each) into a 2-entry register buffer.
- pop = out_valid & out_ready.
- RREQ = !rst & en & !e & ((occ + inflight - pop) < 2).
  - The combinational path from out_ready to RREQ is intentional.
  - RREQ is never asserted when e=1.
- Read latency:
  - If RREQ=1 in cycle t, inflight=1 in cycle t+1.
  - In t+1, RD is written into the buffer at the tail, occ increments, and words_read increments at the t+1 edge.
  - inflight then becomes RREQ(t+1).
- Output:
  - out_valid = (occ != 0).
  - out_data = buffer[head], held stable while out_valid & !out_ready.
  - On pop, head advances and occ decrements.
- Simultaneous push (inflight) and pop: occ is unchanged and both pointers advance.
  - A push into an empty buffer becomes visible on out_valid the next cycle. There is no bypass; minimum latency is RREQ to out_valid = 2 cycles.
- Overflow cannot occur by construction. The bench checks that occ ≤ 2 at all times.
- words_read wraps from 2^CNT_W−1 to 0 with no flag.
- busy = inflight | (occ != 0).
- Deasserting en mid-burst: the in-flight word still lands and the buffer drains normally; RREQ stays 0.
- e rising in the same cycle as a would-be request: RREQ=0 that cycle, with no error state.

Test Plan:
1. Reset, then FIFO preloaded with 0x11, en=1, out_ready=1 → RREQ=1 for exactly one cycle; out_valid=1 with out_data=0x11 two cycles later for one cycle; words_read=1; busy returns to 0.
2. FIFO preloaded with 0x01..0x10, out_ready=1 constantly → RREQ high 16 consecutive cycles; out_data 0x01..0x10 on consecutive cycles with no gaps; words_read=16; no RREQ while e=1.
3. FIFO holding 8 words, out_ready=0 → exactly 2 RREQ pulses, occ=2, out_data=first word held stable; then out_ready=1 → remaining 6 words in order; total words_read=8.
4. Random out_ready (50%) and random writes (e toggling), 1000 words → output sequence equals write sequence; RREQ never high with e=1; occ never exceeds 2.
5. Assert rst for one cycle mid-burst with occ=2 and inflight=1 → next cycle out_valid=0, words_read=0, busy=0; the stray RD word is not emitted; subsequent reads resume with the next FIFO word.
6. CNT_W=4, stream 17 words → words_read reads 0x1 after wrap; en=0 mid-stream → RREQ drops the same cycle and buffered words still drain.
